// File: rtl/vector_exec_writeback_if.sv
// Issue and writeback bundle for vector_exec_writeback.
// slave = stage view, master = upstream/regfile view.
interface vector_exec_writeback_if #(
  parameter int VLEN = 512
);
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        execution_op;
  logic [1:0]        sew;
  logic              mul_high;
  logic [4:0]        vd_addr;
  logic [VLEN-1:0]   sum;
  logic [2*VLEN-1:0] product;
  logic              count_0;
  logic              wb_valid;
  logic              wb_ready;
  logic [VLEN-1:0]   wb_data;
  logic [4:0]        wb_vd;
  logic              wb_illegal;
  logic              mul_timeout;

  modport slave (
    input  issue_valid, execution_op, sew,
    input  mul_high, vd_addr, sum, product,
    input  count_0, wb_ready,
    output issue_ready, wb_valid, wb_data,
    output wb_vd, wb_illegal, mul_timeout
  );

  modport master (
    output issue_valid, execution_op, sew,
    output mul_high, vd_addr, sum, product,
    output count_0, wb_ready,
    input  issue_ready, wb_valid, wb_data,
    input  wb_vd, wb_illegal, mul_timeout
  );
endinterface

// File: rtl/vector_exec_writeback.sv
// Vector exec result collection / writeback stage.
// Optional multiplier watchdog: EXEC_WB_TIMEOUT_EN.
module vector_exec_writeback #(
  parameter int VLEN        = 512,
  parameter int MUL_TIMEOUT = 63
) (
  input logic clk,
  input logic reset,
  vector_exec_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ADD_CAP, WAIT_MUL, HOLD
  } state_t;

  state_t          state_q;
  logic            issue_ready_q;
  logic            wb_valid_q;
  logic [VLEN-1:0] wb_data_q;
  logic [4:0]      wb_vd_q;
  logic            wb_illegal_q;
  logic            mul_timeout_q;
  logic [1:0]      sew_q;
  logic            mul_high_q;

  logic [VLEN-1:0] nar8, nar16, nar32;
  logic [VLEN-1:0] mul_data_d;
  logic            sew_ok, is_add, is_mul;

  // Narrow each double-width product element to SEW bits
  for (genvar i = 0; i < VLEN/8; i++) begin : g_n8
    assign nar8[8*i +: 8] =
      bus.product[16*i + 8*mul_high_q +: 8];
  end
  for (genvar i = 0; i < VLEN/16; i++) begin : g_n16
    assign nar16[16*i +: 16] =
      bus.product[32*i + 16*mul_high_q +: 16];
  end
  for (genvar i = 0; i < VLEN/32; i++) begin : g_n32
    assign nar32[32*i +: 32] =
      bus.product[64*i + 32*mul_high_q +: 32];
  end

  // Pick the narrowing matching the latched SEW
  always_comb begin
    mul_data_d = '0;
    case (sew_q)
      2'b00:   mul_data_d = nar8;
      2'b01:   mul_data_d = nar16;
      2'b10:   mul_data_d = nar32;
      default: mul_data_d = '0;
    endcase
  end

  assign sew_ok = (bus.sew != 2'b11);
  assign is_add = sew_ok && (bus.execution_op == 3'b000);
  assign is_mul = sew_ok && (bus.execution_op == 3'b011);

`ifdef EXEC_WB_TIMEOUT_EN
  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (MUL_TIMEOUT != 0);
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      issue_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_vd_q       <= '0;
      wb_illegal_q  <= 1'b0;
      mul_timeout_q <= 1'b0;
      sew_q         <= '0;
      mul_high_q    <= 1'b0;
`ifdef EXEC_WB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.issue_valid) begin
            sew_q         <= bus.sew;
            mul_high_q    <= bus.mul_high;
            wb_vd_q       <= bus.vd_addr;
            issue_ready_q <= 1'b0;
            wb_illegal_q  <= 1'b0;
            if (is_add) begin
              state_q <= ADD_CAP;
            end else if (is_mul) begin
              state_q <= WAIT_MUL;
`ifdef EXEC_WB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q      <= HOLD;
              wb_data_q    <= '0;
              wb_illegal_q <= 1'b1;
              wb_valid_q   <= 1'b1;
            end
          end
        end
        ADD_CAP: begin
          wb_data_q  <= bus.sum;
          wb_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        WAIT_MUL: begin
          if (bus.count_0) begin
            wb_data_q  <= mul_data_d;
            wb_valid_q <= 1'b1;
            state_q    <= HOLD;
          end
`ifdef EXEC_WB_TIMEOUT_EN
          else if (cnt_q == CW'(MUL_TIMEOUT)) begin
            mul_timeout_q <= 1'b1;
            wb_data_q     <= '0;
            wb_illegal_q  <= 1'b1;
            wb_valid_q    <= 1'b1;
            state_q       <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (bus.wb_ready) begin
            wb_valid_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_vd       = wb_vd_q;
  assign bus.wb_illegal  = wb_illegal_q;
  assign bus.mul_timeout = mul_timeout_q;

endmodule

// File: tb/tb_vector_exec_writeback.sv
// Directed bench for vector_exec_writeback, VLEN=64.
// Timeout scenario runs when EXEC_WB_TIMEOUT_EN is set.
module tb_vector_exec_writeback;
  localparam int VLEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vecs = 0;
  int errs = 0;

  vector_exec_writeback_if #(.VLEN(VLEN)) bus();

  vector_exec_writeback #(
    .VLEN(VLEN), .MUL_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [1:0] s,
                       input logic hi,
                       input logic [4:0] vd);
    bus.execution_op = op;
    bus.sew = s;
    bus.mul_high = hi;
    bus.vd_addr = vd;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    vecs++; if (bus.issue_ready !== 1'b1) begin errs++;
      $display("FAIL rst_ready got %b want 1", bus.issue_ready); end
    vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
      $display("FAIL rst_valid got %b want 0", bus.wb_valid); end
    vecs++; if (bus.wb_data !== 64'h0) begin errs++;
      $display("FAIL rst_data got %h want 0", bus.wb_data); end
    vecs++; if (bus.wb_vd !== 5'd0) begin errs++;
      $display("FAIL rst_vd got %0d want 0", bus.wb_vd); end
    vecs++; if (bus.wb_illegal !== 1'b0) begin errs++;
      $display("FAIL rst_illegal got %b want 0", bus.wb_illegal); end
    vecs++; if (bus.mul_timeout !== 1'b0) begin errs++;
      $display("FAIL rst_timeout got %b want 0", bus.mul_timeout); end
  endtask

  task automatic test_add();
    bus.wb_ready = 1'b1;
    bus.sum = 64'h0000_0005_FFFF_FFFF;
    issue(3'b000, 2'b10, 1'b0, 5'd7);
    vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
      $display("FAIL add_c2_valid got %b want 0", bus.wb_valid); end
    vecs++; if (bus.issue_ready !== 1'b0) begin errs++;
      $display("FAIL add_c2_ready got %b want 0", bus.issue_ready); end
    tick();
    vecs++; if (bus.wb_valid !== 1'b1) begin errs++;
      $display("FAIL add_c3_valid got %b want 1", bus.wb_valid); end
    vecs++; if (bus.wb_data !== 64'h0000_0005_FFFF_FFFF) begin errs++;
      $display("FAIL add_data got %h want 00000005ffffffff", bus.wb_data); end
    vecs++; if (bus.wb_vd !== 5'd7) begin errs++;
      $display("FAIL add_vd got %0d want 7", bus.wb_vd); end
    vecs++; if (bus.wb_illegal !== 1'b0) begin errs++;
      $display("FAIL add_illegal got %b want 0", bus.wb_illegal); end
    vecs++; if (bus.issue_ready !== 1'b0) begin errs++;
      $display("FAIL add_c3_ready got %b want 0", bus.issue_ready); end
    tick();
    vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
      $display("FAIL add_c4_valid got %b want 0", bus.wb_valid); end
    vecs++; if (bus.issue_ready !== 1'b1) begin errs++;
      $display("FAIL add_c4_ready got %b want 1", bus.issue_ready); end
  endtask

  task automatic test_mul_low();
    bus.wb_ready = 1'b1;
    bus.product = {8{16'hABCD}};
    issue(3'b011, 2'b00, 1'b0, 5'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
        $display("FAIL mlo_wait%0d got %b want 0", k, bus.wb_valid); end
    end
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_valid !== 1'b1) begin errs++;
      $display("FAIL mlo_valid got %b want 1", bus.wb_valid); end
    vecs++; if (bus.wb_data !== 64'hCDCD_CDCD_CDCD_CDCD) begin errs++;
      $display("FAIL mlo_data got %h want cdcdcdcdcdcdcdcd", bus.wb_data); end
    vecs++; if (bus.wb_vd !== 5'd3) begin errs++;
      $display("FAIL mlo_vd got %0d want 3", bus.wb_vd); end
    tick();
    vecs++; if (bus.issue_ready !== 1'b1) begin errs++;
      $display("FAIL mlo_idle got %b want 1", bus.issue_ready); end
  endtask

  task automatic test_mul_high();
    bus.wb_ready = 1'b1;
    bus.product = {8{16'hABCD}};
    bus.count_0 = 1'b1;
    issue(3'b011, 2'b00, 1'b1, 5'd4);
    bus.count_0 = 1'b0;
    tick();
    vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
      $display("FAIL mhi_accpulse got %b want 0", bus.wb_valid); end
    tick();
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_data !== 64'hABAB_ABAB_ABAB_ABAB) begin errs++;
      $display("FAIL mhi8_data got %h want abababababababab", bus.wb_data); end
    tick();
    bus.product = {4{32'h1234_5678}};
    issue(3'b011, 2'b01, 1'b1, 5'd5);
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_data !== 64'h1234_1234_1234_1234) begin errs++;
      $display("FAIL mhi16_data got %h want 1234123412341234", bus.wb_data); end
    tick();
    bus.product = {64'h1111_2222_3333_4444,
                   64'h5555_6666_7777_8888};
    issue(3'b011, 2'b10, 1'b0, 5'd6);
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_data !== 64'h3333_4444_7777_8888) begin errs++;
      $display("FAIL mlo32_data got %h want 3333444477778888", bus.wb_data); end
    tick();
  endtask

  task automatic test_illegal();
    bus.wb_ready = 1'b1;
    issue(3'b001, 2'b00, 1'b0, 5'd9);
    vecs++; if (bus.wb_valid !== 1'b1) begin errs++;
      $display("FAIL ill_valid got %b want 1", bus.wb_valid); end
    vecs++; if (bus.wb_data !== 64'h0) begin errs++;
      $display("FAIL ill_data got %h want 0", bus.wb_data); end
    vecs++; if (bus.wb_illegal !== 1'b1) begin errs++;
      $display("FAIL ill_flag got %b want 1", bus.wb_illegal); end
    tick();
    issue(3'b000, 2'b11, 1'b0, 5'd10);
    vecs++; if (bus.wb_valid !== 1'b1 || bus.wb_illegal !== 1'b1) begin errs++;
      $display("FAIL ill_sew got v=%b i=%b want 1 1", bus.wb_valid, bus.wb_illegal); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [VLEN-1:0] held;
    bus.wb_ready = 1'b0;
    bus.sum = 64'hDEAD_BEEF_0123_4567;
    issue(3'b000, 2'b01, 1'b0, 5'd12);
    tick();
    held = 64'hDEAD_BEEF_0123_4567;
    bus.sum = 64'h0;
    for (int k = 0; k < 5; k++) begin
      bus.count_0 = (k == 2);
      vecs++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== held) begin errs++;
        $display("FAIL bp_hold%0d got v=%b d=%h want 1 %h", k, bus.wb_valid, bus.wb_data, held); end
      vecs++; if (bus.issue_ready !== 1'b0) begin errs++;
        $display("FAIL bp_ready%0d got %b want 0", k, bus.issue_ready); end
      tick();
    end
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_data !== held || bus.wb_vd !== 5'd12) begin errs++;
      $display("FAIL bp_after got %h/%0d want %h/12", bus.wb_data, bus.wb_vd, held); end
    bus.wb_ready = 1'b1;
    tick();
    vecs++; if (bus.wb_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin errs++;
      $display("FAIL bp_release got v=%b r=%b want 0 1", bus.wb_valid, bus.issue_ready); end
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b1;
    issue(3'b011, 2'b00, 1'b0, 5'd20);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vecs++; if (bus.issue_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin errs++;
      $display("FAIL rm_hs got r=%b v=%b want 1 0", bus.issue_ready, bus.wb_valid); end
    vecs++; if (bus.wb_data !== 64'h0 || bus.wb_vd !== 5'd0) begin errs++;
      $display("FAIL rm_data got %h/%0d want 0/0", bus.wb_data, bus.wb_vd); end
    vecs++; if (bus.wb_illegal !== 1'b0 || bus.mul_timeout !== 1'b0) begin errs++;
      $display("FAIL rm_flags got %b%b want 00", bus.wb_illegal, bus.mul_timeout); end
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
        $display("FAIL rm_late%0d got %b want 0", k, bus.wb_valid); end
      tick();
    end
  endtask

  task automatic test_timeout();
    bus.wb_ready = 1'b0;
    issue(3'b011, 2'b00, 1'b0, 5'd1);
`ifdef EXEC_WB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      vecs++; if (bus.wb_valid !== 1'b0) begin errs++;
        $display("FAIL to_early%0d got %b want 0", k, bus.wb_valid); end
    end
    tick();
    vecs++; if (bus.wb_valid !== 1'b1 || bus.mul_timeout !== 1'b1) begin errs++;
      $display("FAIL to_fire got v=%b t=%b want 1 1", bus.wb_valid, bus.mul_timeout); end
    vecs++; if (bus.wb_illegal !== 1'b1 || bus.wb_data !== 64'h0) begin errs++;
      $display("FAIL to_data got i=%b d=%h want 1 0", bus.wb_illegal, bus.wb_data); end
    bus.wb_ready = 1'b1;
    tick();
    tick();
    vecs++; if (bus.mul_timeout !== 1'b1) begin errs++;
      $display("FAIL to_sticky got %b want 1", bus.mul_timeout); end
`else
    for (int k = 0; k < 20; k++) tick();
    vecs++; if (bus.wb_valid !== 1'b0 || bus.mul_timeout !== 1'b0) begin errs++;
      $display("FAIL nto_wait got v=%b t=%b want 0 0", bus.wb_valid, bus.mul_timeout); end
    bus.count_0 = 1'b1;
    tick();
    bus.count_0 = 1'b0;
    vecs++; if (bus.wb_valid !== 1'b1) begin errs++;
      $display("FAIL nto_done got %b want 1", bus.wb_valid); end
    bus.wb_ready = 1'b1;
    tick();
`endif
  endtask

  initial begin
    bus.issue_valid = 1'b0;
    bus.execution_op = 3'b000;
    bus.sew = 2'b00;
    bus.mul_high = 1'b0;
    bus.vd_addr = 5'd0;
    bus.sum = '0;
    bus.product = '0;
    bus.count_0 = 1'b0;
    bus.wb_ready = 1'b0;
    test_reset();
    test_add();
    test_mul_low();
    test_mul_high();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vector_exec_writeback.md
# vector_exec_writeback

Result collection and writeback stage directly downstream of the vector execution unit. Accepts one issued vector operation at a time and captures the adder `sum` the cycle after issue, or waits for the multi-cycle multiplier's `count_0` completion pulse. Narrows the double-width `product` to SEW-wide elements, selecting the low or high half. Holds the result in an output register and presents it to the vector register file write port through a valid/ready handshake.

## Interface
Parameters:
- `VLEN`, 512: vector register width in bits; must be a multiple of 32.
- `MUL_TIMEOUT`, 63: multiplier watchdog limit in cycles; used only with `EXEC_WB_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `issue_valid` input 1: an operation is presented for collection.
- `issue_ready` output 1: stage can accept an operation (high only in IDLE).
- `execution_op` input 3: `000` add/sub, `011` multiply, any other value is illegal.
- `sew` input 2: `00` 8-bit, `01` 16-bit, `10` 32-bit, `11` invalid.
- `mul_high` input 1: 1 selects the high SEW half of each product element, 0 the low half.
- `vd_addr` input 5: destination vector register.
- `sum` input VLEN: adder output.
- `product` input 2*VLEN: multiplier output; element i occupies `[2*SEW*i +: 2*SEW]`.
- `count_0` input 1: one-cycle pulse; `product` is valid in that cycle.
- `wb_valid` output 1: writeback data is valid.
- `wb_ready` input 1: register file accepts the writeback.
- `wb_data` output VLEN: result; element i occupies `[SEW*i +: SEW]`.
- `wb_vd` output 5: destination register of `wb_data`.
- `wb_illegal` output 1: the held result comes from an illegal op or SEW; `wb_data` is 0 in that case.
- `mul_timeout` output 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, ADD_CAP, WAIT_MUL, HOLD.
- IDLE:
  - `issue_ready`=1.
  - On `issue_valid`, latch `sew`, `mul_high`, `vd_addr`.
  - `000` with valid SEW → ADD_CAP.
  - `011` with valid SEW → WAIT_MUL.
  - Any other op, or `sew`=`11` → HOLD with `wb_data`=0 and `wb_illegal`=1.
- ADD_CAP: register `sum` into `wb_data` → HOLD. Upstream keeps operands stable while `issue_ready`=0.
- WAIT_MUL:
  - Wait for `count_0`=1.
  - For each element, take bits `[2*SEW*i + SEW*mul_high +: SEW]` of `product` into `wb_data` `[SEW*i +: SEW]` → HOLD.
  - Element count is VLEN/SEW, using the latched SEW.
- HOLD:
  - `wb_valid`=1; `wb_data`, `wb_vd`, `wb_illegal` stay stable.
  - On `wb_ready`=1 → IDLE. `wb_valid` drops the next cycle.
- A `count_0` pulse outside WAIT_MUL is ignored, including one in the acceptance cycle.
- Reset mid-operation: return to IDLE and discard the pending result. `count_0` arriving later is ignored.

## Timing
- Reset values: state IDLE, `issue_ready`=1, `wb_valid`=0, `wb_data`=0, `wb_vd`=0, `wb_illegal`=0, `mul_timeout`=0.
- Add: accepted in cycle N → `sum` sampled in N+1 → `wb_valid` in N+2.
- Multiply: `count_0` in cycle M → `wb_valid` in M+1.
- Illegal op: accepted in cycle N → `wb_valid` in N+1.
- `wb_ready` already high when `wb_valid` rises: one-cycle HOLD, back in IDLE the next cycle. `issue_ready` is high in that cycle.
- Back-to-back throughput is at most one op every 3 cycles for add. `issue_ready` is never high while `wb_valid` is high.

## Configuration
- `EXEC_WB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_MUL and clears on entry.
  - If it reaches `MUL_TIMEOUT` without `count_0`: set `mul_timeout`, go to HOLD with `wb_data`=0 and `wb_illegal`=1.
  - `mul_timeout` clears only on reset.
- `EXEC_WB_TIMEOUT_EN` undefined: no counter; WAIT_MUL waits indefinitely; `mul_timeout` is tied to 0.

## Test plan
Bench uses VLEN=64.
- Add: `sew`=10, `sum`=0x0000_0005_FFFF_FFFF, issue in cycle 1 with `wb_ready`=1 → `wb_valid` in cycle 3, `wb_data`=0x0000_0005_FFFF_FFFF, `wb_vd` equals the issued `vd_addr`, then IDLE in cycle 4.
- Mul low: `sew`=00, `mul_high`=0, all product elements 0xABCD, `count_0` 4 cycles after issue → `wb_data`=0xCDCD_CDCD_CDCD_CDCD one cycle after `count_0`.
- Mul high: same stimulus with `mul_high`=1 → `wb_data`=0xABAB_ABAB_ABAB_ABAB. With `sew`=01 and elements 0x1234_5678 → `wb_data`=0x1234_1234_1234_1234.
- Backpressure: hold `wb_ready`=0 for 5 cycles → `wb_valid` and `wb_data` stay stable, `issue_ready`=0, and an extra `count_0` pulse has no effect. Raise `wb_ready` → IDLE next cycle.
- Illegal and reset:
  - `execution_op`=`001` → `wb_valid` one cycle later, `wb_data`=0, `wb_illegal`=1.
  - `reset`=0 during WAIT_MUL → all outputs at reset values next cycle, and a following `count_0` produces no `wb_valid`.
- Timeout (macro defined, `MUL_TIMEOUT`=8): no `count_0` → `mul_timeout`=1 and `wb_illegal`=1 with `wb_valid` raised 9 cycles after WAIT_MUL entry.
